// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data BRAM between the CPU load/store path and an
// auxiliary master (UART loader / copy engine). Grants are combinational and
// zero-latency; read data comes straight from the BRAM one cycle after the
// grant and is qualified by a registered rvalid per requester.
//
// The CPU wins every tie. The auxiliary master cannot starve, because a
// saturating wait counter forces it through after STARVE_LIMIT consecutive
// denied cycles. A denied CPU request is the CPU stall.
//
// Optional feature macro: DMEM_ARB_PERF_EN
//   defined   : cnt_conflict counts cycles with both requests high (wraps)
//   undefined : cnt_conflict is tied to zero and no counter is built
//
// Parameters:
//   ADDR_W       word-address width
//   STARVE_LIMIT denied aux cycles before aux is forced through (1..255)
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   cpu_req/we/adr/wdata              CPU request fields
//   cpu_gnt, cpu_rvalid, cpu_rdata    CPU responses
//   aux_req/we/adr/wdata              auxiliary request fields
//   aux_gnt, aux_rvalid, aux_rdata    auxiliary responses
//   mem_adr, mem_din, mem_wea         BRAM port A controls
//   mem_dout                          BRAM read data (registered in BRAM)
//   cnt_conflict                      conflict-cycle counter
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              aux_req,
  input  logic [3:0]        aux_we,
  input  logic [ADDR_W-1:0] aux_adr,
  input  logic [31:0]       aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [31:0]       aux_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wea,
  input  logic [31:0]       mem_dout,
  output logic [31:0]       cnt_conflict
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rd_cpu_q, rd_cpu_d;
  logic       rd_aux_q, rd_aux_d;
  logic       force_aux;

  // Grant decision and BRAM port mux. When nobody is granted the CPU fields
  // still drive the address so a stalled CPU keeps a stable BRAM address, but
  // the write enables are forced to zero.
  always_comb begin
    force_aux = aux_req && (starve_cnt_q >= LIMIT);
    aux_gnt   = aux_req && (!cpu_req || force_aux);
    cpu_gnt   = cpu_req && !aux_gnt;

    if (aux_gnt) begin
      mem_adr = aux_adr;
      mem_din = aux_wdata;
      mem_wea = aux_we;
    end else begin
      mem_adr = cpu_adr;
      mem_din = cpu_wdata;
      mem_wea = cpu_gnt ? cpu_we : 4'h0;
    end
  end

  // Next-state for the starvation counter and the read trackers. The counter
  // only grows while aux is actually waiting and saturates instead of wrapping.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (aux_gnt || !aux_req) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q != 8'hFF) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    rd_cpu_d = cpu_gnt && (cpu_we == 4'h0);
    rd_aux_d = aux_gnt && (aux_we == 4'h0);
  end

  // State registers. Async reset drops any pending rvalid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 8'd0;
      rd_cpu_q     <= 1'b0;
      rd_aux_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_cpu_q     <= rd_cpu_d;
      rd_aux_q     <= rd_aux_d;
    end
  end

  // Both requesters see the raw BRAM output; rvalid says whose data it is.
  assign cpu_rvalid = rd_cpu_q;
  assign aux_rvalid = rd_aux_q;
  assign cpu_rdata  = mem_dout;
  assign aux_rdata  = mem_dout;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cnt_conflict_q, cnt_conflict_d;

  // Counts every cycle in which both masters want the port; wraps naturally.
  always_comb begin
    cnt_conflict_d = cnt_conflict_q;
    if (cpu_req && aux_req) begin
      cnt_conflict_d = cnt_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_conflict_q <= 32'd0;
    end else begin
      cnt_conflict_q <= cnt_conflict_d;
    end
  end

  assign cnt_conflict = cnt_conflict_q;
`else
  assign cnt_conflict = 32'd0;
`endif

endmodule
